// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one instruction-memory request per PC, waits
// for the response and hands the word to decode, then pulses pc_update so the
// PC register advances. A flush from execute discards the fetch in flight.
// Misaligned PCs (when CHECK_ALIGN=1) never reach memory and instead produce
// a faulting NOP.
`timescale 1ns/1ps
module ifu_fetch #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_update,
  input  logic        flush,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  // Canonical NOP (addi x0, x0, 0) delivered in place of a misaligned fetch.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] addr_q, addr_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        rsp_ready_q, rsp_ready_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_fault_q, inst_fault_d;

  logic        misaligned;

  assign misaligned = CHECK_ALIGN && (pc[1:0] != 2'b00);

  // Next-state and next-output logic; every output is registered so decode
  // and memory see glitch-free, stable handshake signals.
  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    addr_d       = addr_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    rsp_ready_d  = rsp_ready_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;

    unique case (state_q)
      S_IDLE: begin
        // A redirect arriving while idle means pc is about to change, so
        // sampling it now would fetch from a stale address.
        if (!flush) begin
          addr_d = pc;
          if (misaligned) begin
            state_d      = S_HOLD;
            inst_valid_d = 1'b1;
            inst_d       = NOP_INST;
            inst_fault_d = 1'b1;
            inst_pc_d    = pc;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_addr_d  = pc;
          end
        end
      end

      S_REQ: begin
        // The request cannot be withdrawn once offered; a flush only marks
        // the eventual response for discard.
        if (flush) begin
          drop_d = 1'b1;
        end
        if (req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
          rsp_ready_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (rsp_valid) begin
          rsp_ready_d = 1'b0;
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d      = S_HOLD;
            inst_valid_d = 1'b1;
            inst_d       = rsp_data;
            inst_fault_d = rsp_err;
            inst_pc_d    = addr_q;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        // Flush takes priority over the handoff; either way the held word is
        // retired and the next PC is sampled from IDLE.
        if (flush || inst_ready) begin
          state_d      = S_IDLE;
          inst_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      drop_q       <= 1'b0;
      addr_q       <= 32'h0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= 32'h0;
      rsp_ready_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      addr_q       <= addr_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      rsp_ready_q  <= rsp_ready_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  assign req_valid  = req_valid_q;
  assign req_addr   = req_addr_q;
  assign rsp_ready  = rsp_ready_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

  // The PC write-enable follows the decode handshake directly so the PC
  // register advances in the same cycle the word is taken.
  assign pc_update = inst_valid_q && inst_ready && !flush;

`ifndef SYNTHESIS
  // An offered request must stay put until memory accepts it.
  a_req_stable: assert property (@(posedge clk) disable iff (!rst)
    (req_valid && !req_ready) |=> (req_valid && $stable(req_addr)));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios with literal expectations, then a
// randomized run with a responder, a PC register and a transaction-level
// model of the fetch protocol compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_ifu_fetch;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam bit          CHK_ALIGN = 1'b1;
  localparam int          BUDGET    = 50;
  // Abstract phases of one fetch as seen at the interfaces.
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_WAIT = 2;
  localparam int P_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_update;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the fetch in progress.
  int          m_ph = P_IDLE;
  logic        m_drop = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_ipc = 32'h0;
  logic        m_fault = 1'b0;
  logic        exp_pcu;

  // Events predicted for the coming clock edge.
  logic ev_req_acc = 1'b0;
  logic ev_rsp_acc = 1'b0;
  logic ev_pcu = 1'b0;
  logic ev_flush = 1'b0;

  int pcu_seen = 0;
  int rv_seen = 0;
  int iv_seen = 0;

  // Responder and stimulus knobs.
  logic [31:0] redirect_pc = 32'h0;
  logic        resp_have = 1'b0;
  logic [31:0] resp_d = 32'h0;
  logic        resp_e = 1'b0;
  int          resp_wait = 0;
  bit          use_force = 1'b0;
  logic [31:0] force_data = 32'h0;
  logic        force_err = 1'b0;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          garbage_en = 1'b0;

  always #5 clk = ~clk;

  ifu_fetch #(.CHECK_ALIGN(CHK_ALIGN)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_update  (pc_update),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by the rules
  // of the fetch protocol using the inputs that will be seen at the next edge.
  task automatic compare_cycle();
    if (!rst) begin
      chk1 ("rst_req_valid",  req_valid,  1'b0);
      chk32("rst_req_addr",   req_addr,   32'h0);
      chk1 ("rst_rsp_ready",  rsp_ready,  1'b0);
      chk1 ("rst_inst_valid", inst_valid, 1'b0);
      chk32("rst_inst",       inst,       32'h0);
      chk32("rst_inst_pc",    inst_pc,    32'h0);
      chk1 ("rst_inst_fault", inst_fault, 1'b0);
      chk1 ("rst_pc_update",  pc_update,  1'b0);
      m_ph = P_IDLE;
      m_drop = 1'b0;
      m_addr = 32'h0;
      ev_req_acc = 1'b0;
      ev_rsp_acc = 1'b0;
      ev_pcu = 1'b0;
      ev_flush = 1'b0;
    end else begin
      exp_pcu = (m_ph == P_HOLD) && inst_ready && !flush;
      chk1("req_valid",  req_valid,  m_ph == P_REQ);
      if (m_ph == P_REQ) chk32("req_addr", req_addr, m_addr);
      chk1("rsp_ready",  rsp_ready,  m_ph == P_WAIT);
      chk1("inst_valid", inst_valid, m_ph == P_HOLD);
      chk1("pc_update",  pc_update,  exp_pcu);
      if (m_ph == P_HOLD) begin
        chk32("inst",       inst,       m_inst);
        chk32("inst_pc",    inst_pc,    m_ipc);
        chk1 ("inst_fault", inst_fault, m_fault);
      end
      ev_req_acc = (m_ph == P_REQ) && req_ready;
      ev_rsp_acc = (m_ph == P_WAIT) && rsp_valid;
      ev_pcu = exp_pcu;
      ev_flush = flush;
      case (m_ph)
        P_IDLE: if (!flush) begin
          m_addr = pc;
          if (CHK_ALIGN && (pc[1:0] != 2'b00)) begin
            m_ph = P_HOLD;
            m_inst = NOP_INST;
            m_fault = 1'b1;
            m_ipc = pc;
          end else begin
            m_ph = P_REQ;
          end
        end
        P_REQ: begin
          if (flush) m_drop = 1'b1;
          if (req_ready) m_ph = P_WAIT;
        end
        P_WAIT: begin
          if (rsp_valid) begin
            if (m_drop || flush) begin
              m_drop = 1'b0;
              m_ph = P_IDLE;
            end else begin
              m_inst = rsp_data;
              m_fault = rsp_err;
              m_ipc = m_addr;
              m_ph = P_HOLD;
            end
          end else if (flush) begin
            m_drop = 1'b1;
          end
        end
        default: if (flush || inst_ready) m_ph = P_IDLE;
      endcase
    end
    if (pc_update === 1'b1) pcu_seen++;
    if (req_valid === 1'b1) rv_seen++;
    if (inst_valid === 1'b1) iv_seen++;
  endtask

  // One clock: compare at the falling edge, then after the rising edge apply
  // the PC register and memory responder updates and drive the responder.
  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    if (!rst) begin
      resp_have = 1'b0;
    end else begin
      if (ev_flush) pc = redirect_pc;
      else if (ev_pcu) pc = pc + 32'd4;
      if (ev_rsp_acc) resp_have = 1'b0;
      else if (resp_have && resp_wait > 0) resp_wait--;
      if (ev_req_acc) begin
        resp_have = 1'b1;
        resp_wait = $urandom_range(lat_max, lat_min);
        resp_d = use_force ? force_data : $urandom;
        resp_e = use_force ? force_err : ($urandom_range(7, 0) == 0);
      end
    end
    if (resp_have) begin
      rsp_valid = (resp_wait == 0);
      rsp_data = resp_d;
      rsp_err = resp_e;
    end else begin
      rsp_valid = garbage_en ? ($urandom_range(3, 0) == 0) : 1'b0;
      rsp_data = $urandom;
      rsp_err = ($urandom_range(1, 0) == 1);
    end
  endtask

  // Advance until req_valid (which=0) or inst_valid (which=1), bounded.
  task automatic run_until(input int which, input string name, output int n);
    n = 0;
    while (!((which == 0) ? (req_valid === 1'b1) : (inst_valid === 1'b1)) && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no event within %0d cycles", name, BUDGET);
    end
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int c;
    int n1;
    int n2;
    logic [31:0] r;
    rst = 1'b0; pc = 32'h0; flush = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = 32'h0; rsp_err = 1'b0; inst_ready = 1'b0;
    repeat (3) tick();
    chk1 ("reset_req_valid",  req_valid,  1'b0);
    chk1 ("reset_inst_valid", inst_valid, 1'b0);

    // Basic fetch at 0x80000000 with a ready memory and next-cycle response.
    use_force = 1'b1; force_data = 32'h0010_0093; force_err = 1'b0;
    lat_min = 0; lat_max = 0;
    pc = 32'h8000_0000; req_ready = 1'b1; inst_ready = 1'b1; rst = 1'b1;
    run_until(0, "t1_req", n1);
    chk32("t1_req_addr", req_addr, 32'h8000_0000);
    c = pcu_seen;
    run_until(1, "t1_inst", n1);
    chk32("t1_inst",       inst,       32'h0010_0093);
    chk32("t1_inst_pc",    inst_pc,    32'h8000_0000);
    chk1 ("t1_inst_fault", inst_fault, 1'b0);
    chk1 ("t1_pc_update",  pc_update,  1'b1);
    run_until(0, "t1_next_req", n2);
    chk32("t1_next_addr", req_addr, 32'h8000_0004);
    chk32("t1_pulses", pcu_seen - c, 32'd1);
    chk32("t1_issue_interval", n1 + n2, 32'd4);

    // Decode backpressure while holding the word for 0x80000004.
    inst_ready = 1'b0; force_data = 32'hCAFE_0001;
    run_until(1, "t2_inst", n1);
    c = pcu_seen;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk32("t2_inst",    inst,    32'hCAFE_0001);
      chk32("t2_inst_pc", inst_pc, 32'h8000_0004);
    end
    chk32("t2_no_pulse", pcu_seen - c, 32'd0);
    inst_ready = 1'b1;
    #1;
    chk1("t2_pc_update", pc_update, 1'b1);
    tick();
    tick();
    chk32("t2_one_pulse", pcu_seen - c, 32'd1);

    // Flush while waiting on memory, redirect to 0x80000100.
    lat_min = 2; lat_max = 2;
    tick();
    chk1("t3_rsp_ready", rsp_ready, 1'b1);
    flush = 1'b1; redirect_pc = 32'h8000_0100; c = iv_seen;
    tick();
    flush = 1'b0;
    run_until(0, "t3_req", n1);
    chk32("t3_req_addr", req_addr, 32'h8000_0100);
    chk32("t3_no_inst", iv_seen - c, 32'd0);

    // Misaligned PC: no memory request, faulting NOP.
    lat_min = 0; lat_max = 0;
    run_until(1, "t4_prev", n1);
    chk32("t4_prev_pc", inst_pc, 32'h8000_0100);
    tick();
    pc = 32'h8000_0002; c = rv_seen;
    run_until(1, "t4_inst", n1);
    chk32("t4_inst",       inst,       NOP_INST);
    chk1 ("t4_inst_fault", inst_fault, 1'b1);
    chk32("t4_inst_pc",    inst_pc,    32'h8000_0002);
    chk32("t4_no_req",     rv_seen - c, 32'd0);

    // Memory error propagates with the returned data.
    tick();
    pc = 32'h8000_0200; force_data = 32'hDEAD_BEEF; force_err = 1'b1;
    run_until(1, "t5_inst", n1);
    chk32("t5_inst",       inst,       32'hDEAD_BEEF);
    chk1 ("t5_inst_fault", inst_fault, 1'b1);
    chk32("t5_inst_pc",    inst_pc,    32'h8000_0200);
    force_err = 1'b0;

    // Flush and inst_ready together in HOLD: flush wins.
    flush = 1'b1; redirect_pc = 32'h8000_0300;
    #1;
    chk1("t6_pc_update", pc_update, 1'b0);
    c = pcu_seen;
    tick();
    flush = 1'b0;
    chk1("t6_inst_valid", inst_valid, 1'b0);
    run_until(0, "t6_req", n1);
    chk32("t6_req_addr", req_addr, 32'h8000_0300);
    chk32("t6_no_pulse", pcu_seen - c, 32'd0);

    // Reset during a stalled request.
    req_ready = 1'b0;
    tick();
    chk1("t7_req_pending", req_valid, 1'b1);
    c = pcu_seen;
    rst = 1'b0;
    #1;
    chk1 ("t7_req_valid",  req_valid,  1'b0);
    chk32("t7_req_addr",   req_addr,   32'h0);
    chk1 ("t7_rsp_ready",  rsp_ready,  1'b0);
    chk1 ("t7_inst_valid", inst_valid, 1'b0);
    chk32("t7_inst",       inst,       32'h0);
    chk32("t7_inst_pc",    inst_pc,    32'h0);
    chk1 ("t7_inst_fault", inst_fault, 1'b0);
    chk1 ("t7_pc_update",  pc_update,  1'b0);
    tick();
    tick();
    req_ready = 1'b1; rst = 1'b1;
    run_until(0, "t7_restart", n1);
    chk32("t7_restart_addr", req_addr, 32'h8000_0300);
    chk32("t7_no_pulse", pcu_seen - c, 32'd0);

    // Randomized traffic.
    use_force = 1'b0; lat_min = 0; lat_max = 3; garbage_en = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (!rst) rst = ($urandom_range(1, 0) == 0);
      else if ($urandom_range(299, 0) == 0) rst = 1'b0;
      req_ready = ($urandom_range(3, 0) != 0);
      inst_ready = ($urandom_range(9, 0) < 7);
      flush = ($urandom_range(11, 0) == 0);
      r = $urandom;
      redirect_pc = ($urandom_range(7, 0) == 0) ? r : {r[31:2], 2'b00};
      if ($urandom_range(63, 0) == 0) begin
        r = $urandom;
        pc = r;
      end
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL have parameter CHECK_ALIGN, default 1, meaning: when 1, a PC with pc[1:0]!=0 raises a fetch fault and issues no memory request.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous, active-low (0 = reset asserted).
REQ-004 The block SHALL have port pc, input, 32, the current PC from the PC register.
REQ-005 The block SHALL have port pc_update, output, 1, the PC write-enable pulse (advance to PC+4 or the selected target).
REQ-006 The block SHALL have port flush, input, 1, a redirect from execute that discards the in-flight fetch.
REQ-007 The block SHALL have ports req_valid (output, 1), req_ready (input, 1), req_addr (output, 32): the instruction-memory request channel.
REQ-008 The block SHALL have ports rsp_valid (input, 1), rsp_ready (output, 1), rsp_data (input, 32), rsp_err (input, 1): the instruction-memory response channel.
REQ-009 The block SHALL have ports inst_valid (output, 1), inst_ready (input, 1), inst (output, 32), inst_pc (output, 32), inst_fault (output, 1): the decode handoff channel.

Function
REQ-010 The block SHALL implement states IDLE, REQ, WAIT, HOLD, with at most one outstanding memory request.
REQ-011 In IDLE with flush=0, the block SHALL latch addr_q<=pc; go to HOLD with fault if CHECK_ALIGN=1 and pc[1:0]!=0, else go to REQ.
REQ-012 In IDLE with flush=1, the block SHALL stay in IDLE and latch nothing.
REQ-013 In REQ, the block SHALL drive req_valid=1 and req_addr=addr_q; it goes to WAIT on req_valid&&req_ready.
REQ-014 Once asserted, req_valid and req_addr SHALL hold stable until accepted, including when flush is asserted.
REQ-015 rsp_ready SHALL be 1 exactly when state==WAIT; rsp_valid in any other state is ignored.
REQ-016 In WAIT on rsp_valid with no drop pending, the block SHALL capture inst<=rsp_data, inst_fault<=rsp_err, inst_pc<=addr_q, and go to HOLD.
REQ-017 In HOLD, the block SHALL drive inst_valid=1 and keep inst, inst_pc and inst_fault stable until handoff.
REQ-018 pc_update SHALL equal inst_valid && inst_ready && !flush; it is asserted only in HOLD, for exactly one cycle per handoff.
REQ-019 On handoff the block SHALL go from HOLD to IDLE, so the updated pc is sampled one cycle later.
REQ-020 Minimum issue interval SHALL be 4 cycles (IDLE, REQ, WAIT, HOLD) with req_ready=1 and a next-cycle response.
REQ-021 On a misaligned fault, the block SHALL set inst=32'h00000013, inst_fault=1 and inst_pc=addr_q.
REQ-022 On flush in REQ or WAIT, the block SHALL set drop_q=1; the request (if pending) completes normally, the next response is consumed and discarded, drop_q clears and the state returns to IDLE.
REQ-023 When flush and rsp_valid coincide in WAIT, the response SHALL be discarded and the state SHALL go to IDLE.
REQ-024 When flush and inst_ready coincide in HOLD, flush SHALL win: no pc_update, inst_valid drops next cycle, state goes to IDLE.
REQ-025 The memory responder SHALL share rst, so no response from before reset is delivered after reset.

Reset
REQ-026 While rst=0, the block SHALL immediately set state=IDLE, drop_q=0, addr_q=0, and outputs req_valid, req_addr, rsp_ready, inst_valid, inst, inst_pc, inst_fault, pc_update to 0.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction with no pc_update.
REQ-028 After rst rises, the first rising edge SHALL sample pc in IDLE.

Verification
REQ-029 Basic fetch: pc=32'h80000000, mem ready, rsp next cycle with data 32'h00100093 -> req_addr=80000000; inst=00100093, inst_pc=80000000, inst_fault=0; one pc_update pulse; next req_addr=80000004.
REQ-030 Decode backpressure: inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, pc_update=0 throughout; a single pulse when inst_ready=1.
REQ-031 Flush during WAIT, then pc redirected to 32'h80000100 -> stale response is discarded with no inst_valid; next req_addr=80000100.
REQ-032 Misaligned: pc=32'h80000002, CHECK_ALIGN=1 -> no req_valid; inst_valid with inst=00000013, inst_fault=1, inst_pc=80000002.
REQ-033 Memory error: rsp_err=1 -> inst_fault=1 and inst=rsp_data on the handoff.
REQ-034 Reset mid-transaction: rst=0 during REQ with req_ready=0 -> all outputs 0 at once; after release, the fetch restarts from the current pc.
